// File: rtl/param_dp_memory.sv
// Dual-port synchronous RAM. Port A reads, port B reads or writes.
// An optional post-reset sweep zero-fills every word before the ports open.
module param_dp_memory #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] instr_out,
  output logic              valid_a,
  input  logic              re_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] write_data_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_b,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic              valid_a_q, valid_a_d;
  logic              valid_b_q, valid_b_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    instr_d   = instr_q;
    data_b_d  = data_b_q;
    valid_a_d = 1'b0;
    valid_b_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_b;
    mem_wdata = write_data_b;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        instr_d   = '0;
        data_b_d  = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = READY;
      end
      READY: begin
        if (re_a) begin
          valid_a_d = 1'b1;
          // Write-first forwards the incoming port B data on an address match.
          if (RDW_MODE == 0 && we_b && addr_a == addr_b) instr_d = write_data_b;
          else                                            instr_d = mem_q[addr_a];
        end
        if (we_b) begin
          mem_we    = 1'b1;
          valid_b_d = 1'b1;
          data_b_d  = (RDW_MODE == 0) ? write_data_b : mem_q[addr_b];
        end else if (re_b) begin
          valid_b_d = 1'b1;
          data_b_d  = mem_q[addr_b];
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
      clr_cnt_q <= '0;
      instr_q   <= '0;
      data_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      instr_q   <= instr_d;
      data_b_q  <= data_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign instr_out  = instr_q;
  assign data_out_b = data_b_q;
  assign valid_a    = valid_a_q;
  assign valid_b    = valid_b_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_param_dp_memory.sv
// Scoreboard bench for param_dp_memory across four parameter sets.
module tb_param_dp_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [15:0] d;
    int unsigned c;
  } exp_t;

  exp_t  q [8][$];
  string chn [8] = '{"u0.a", "u0.b", "u1.a", "u1.b", "u2.a", "u2.b", "u3.a", "u3.b"};
  logic  busy3_seen = 1'b0;

  // u0: ADDR_W=4, clearing
  logic       rst0 = 1'b1, re_a0 = 1'b0, re_b0 = 1'b0, we_b0 = 1'b0;
  logic [3:0] addr_a0 = '0, addr_b0 = '0;
  logic [7:0] wd0 = '0, ia0, db0;
  logic       va0, vb0, busy0;

  // u1 (write-first) and u2 (read-first) share stimulus
  logic       rst1 = 1'b1, re_a1 = 1'b0, re_b1 = 1'b0, we_b1 = 1'b0;
  logic [7:0] addr_a1 = '0, addr_b1 = '0, wd1 = '0;
  logic [7:0] ia1, db1, ia2, db2;
  logic       va1, vb1, busy1, va2, vb2, busy2;

  // u3: DATA_W=16, no clear
  logic        rst3 = 1'b1, re_a3 = 1'b0, re_b3 = 1'b0, we_b3 = 1'b0;
  logic [7:0]  addr_a3 = '0, addr_b3 = '0;
  logic [15:0] wd3 = '0, ia3, db3;
  logic        va3, vb3, busy3;

  param_dp_memory #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0), .CLEAR_ON_RST(1)) u0 (
    .clk(clk), .rst(rst0), .re_a(re_a0), .addr_a(addr_a0), .instr_out(ia0), .valid_a(va0),
    .re_b(re_b0), .we_b(we_b0), .addr_b(addr_b0), .write_data_b(wd0),
    .data_out_b(db0), .valid_b(vb0), .busy(busy0));

  param_dp_memory #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(0), .CLEAR_ON_RST(1)) u1 (
    .clk(clk), .rst(rst1), .re_a(re_a1), .addr_a(addr_a1), .instr_out(ia1), .valid_a(va1),
    .re_b(re_b1), .we_b(we_b1), .addr_b(addr_b1), .write_data_b(wd1),
    .data_out_b(db1), .valid_b(vb1), .busy(busy1));

  param_dp_memory #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(1), .CLEAR_ON_RST(1)) u2 (
    .clk(clk), .rst(rst1), .re_a(re_a1), .addr_a(addr_a1), .instr_out(ia2), .valid_a(va2),
    .re_b(re_b1), .we_b(we_b1), .addr_b(addr_b1), .write_data_b(wd1),
    .data_out_b(db2), .valid_b(vb2), .busy(busy2));

  param_dp_memory #(.DATA_W(16), .ADDR_W(8), .RDW_MODE(0), .CLEAR_ON_RST(0)) u3 (
    .clk(clk), .rst(rst3), .re_a(re_a3), .addr_a(addr_a3), .instr_out(ia3), .valid_a(va3),
    .re_b(re_b3), .we_b(we_b3), .addr_b(addr_b3), .write_data_b(wd3),
    .data_out_b(db3), .valid_b(vb3), .busy(busy3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected value becomes visible after the next rising edge.
  task automatic push(input int ch, input logic [15:0] d);
    q[ch].push_back('{d: d, c: cyc + 1});
  endtask

  task automatic pop_check(input int ch, input logic v, input logic [15:0] d);
    exp_t e;
    if (!v) return;
    if (q[ch].size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s unexpected valid: got data %h, expected no response", chn[ch], d);
    end else begin
      e = q[ch].pop_front();
      check({chn[ch], " data"}, 32'(d), 32'(e.d));
      check({chn[ch], " latency"}, cyc, e.c);
    end
  endtask

  initial forever begin
    @(negedge clk);
    pop_check(0, va0, 16'(ia0));
    pop_check(1, vb0, 16'(db0));
    pop_check(2, va1, 16'(ia1));
    pop_check(3, vb1, 16'(db1));
    pop_check(4, va2, 16'(ia2));
    pop_check(5, vb2, 16'(db2));
    pop_check(6, va3, ia3);
    pop_check(7, vb3, db3);
    if (busy3) busy3_seen = 1'b1;
  end

  // One shared-stimulus cycle for u1/u2; negative expectation = no response.
  task automatic step1(input logic ra, input logic [7:0] aa, input logic rb, input logic wb,
                       input logic [7:0] ab, input logic [7:0] wd,
                       input int ea1, input int eb1, input int ea2, input int eb2);
    re_a1 = ra; addr_a1 = aa; re_b1 = rb; we_b1 = wb; addr_b1 = ab; wd1 = wd;
    if (ea1 >= 0) push(2, 16'(ea1));
    if (eb1 >= 0) push(3, 16'(eb1));
    if (ea2 >= 0) push(4, 16'(ea2));
    if (eb2 >= 0) push(5, 16'(eb2));
    @(negedge clk);
  endtask

  task automatic count_busy0(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("u0 reset busy", busy0, 1);
    check("u0 reset instr", ia0, 0);
    check("u0 reset data_b", db0, 0);
    check("u0 reset valids", {va0, vb0}, 0);
    check("u1 reset busy", busy1, 1);
    check("u3 reset busy", busy3, 0);
    rst0 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
    count_busy0(n);
    check("u0 clear length", n, 16);

    for (int i = 0; i < 16; i++) begin
      re_a0 = 1'b1; addr_a0 = 4'(i);
      re_b0 = 1'b1; addr_b0 = 4'(15 - i);
      push(0, 16'h0); push(1, 16'h0);
      @(negedge clk);
    end
    re_a0 = 1'b0; re_b0 = 1'b0;
    we_b0 = 1'b1; addr_b0 = 4'd3; wd0 = 8'h55; push(1, 16'h55);
    @(negedge clk);
    we_b0 = 1'b0; re_a0 = 1'b1; addr_a0 = 4'd3; push(0, 16'h55);
    @(negedge clk);
    re_a0 = 1'b0;

    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    repeat (7) @(negedge clk);
    check("u0 busy mid-clear", busy0, 1);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    we_b0 = 1'b1; addr_b0 = 4'd3; wd0 = 8'h77;
    re_a0 = 1'b1; addr_a0 = 4'd3;
    count_busy0(n);
    check("u0 clear after re-reset", n, 16);
    we_b0 = 1'b0;
    push(0, 16'h0);
    @(negedge clk);
    re_a0 = 1'b0;

    n = 0;
    while ((busy1 || busy2) && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("u1/u2 clear done", {busy1, busy2}, 0);
    step1(0, 0,  0, 1, 5,  8'hAA, -1,   'hAA, -1,   'h00);
    step1(0, 0,  1, 0, 5,  0,     -1,   'hAA, -1,   'hAA);
    step1(0, 0,  0, 0, 0,  0,     -1,   -1,   -1,   -1);
    check("u1 idle valid_b", vb1, 0);
    check("u1 idle hold", db1, 8'hAA);
    check("u2 idle valid_b", vb2, 0);
    check("u2 idle hold", db2, 8'hAA);
    step1(0, 0,  0, 1, 20, 8'h11, -1,   'h11, -1,   'h00);
    step1(1, 20, 0, 1, 20, 8'hF0, 'hF0, 'hF0, 'h11, 'h11);
    step1(0, 0,  0, 1, 10, 8'h33, -1,   'h33, -1,   'h00);
    step1(1, 10, 0, 1, 5,  8'h55, 'h33, 'h55, 'h33, 'hAA);
    step1(1, 20, 1, 0, 5,  0,     'hF0, 'h55, 'hF0, 'h55);
    step1(0, 0,  0, 0, 0,  0,     -1,   -1,   -1,   -1);
    check("u1 idle valid_a", va1, 0);

    we_b3 = 1'b1; addr_b3 = 8'hFF; wd3 = 16'hBEEF; push(7, 16'hBEEF);
    @(negedge clk);
    we_b3 = 1'b0; rst3 = 1'b1;
    @(negedge clk);
    check("u3 reset data_b", db3, 0);
    check("u3 reset valid_b", vb3, 0);
    check("u3 busy after reset", busy3, 0);
    rst3 = 1'b0;
    re_a3 = 1'b1; addr_a3 = 8'hFF; re_b3 = 1'b1; addr_b3 = 8'hFF;
    push(6, 16'hBEEF); push(7, 16'hBEEF);
    @(negedge clk);
    re_a3 = 1'b0; re_b3 = 1'b0;

    repeat (3) @(negedge clk);
    check("u3 busy ever high", busy3_seen, 0);
    for (int ch = 0; ch < 8; ch++) check({chn[ch], " missing responses"}, q[ch].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_dp_memory.md
PARAM_DP_MEMORY -- requirements
Module: param_dp_memory

Interface
REQ-001 SHALL have parameter DATA_W, 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RDW_MODE, 0, same-address read-during-write policy: 0 = write-first (new data), 1 = read-first (old data).
REQ-004 SHALL have parameter CLEAR_ON_RST, 1, 1 = zero-fill all words after reset; 0 = contents untouched by reset.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port re_a  input  1  port A (instruction) read enable.
REQ-008 SHALL have port addr_a  input  ADDR_W  port A read address.
REQ-009 SHALL have port instr_out  output  DATA_W  port A registered read data.
REQ-010 SHALL have port valid_a  output  1  instr_out updated this cycle.
REQ-011 SHALL have port re_b  input  1  port B (data) read enable.
REQ-012 SHALL have port we_b  input  1  port B write enable.
REQ-013 SHALL have port addr_b  input  ADDR_W  port B address.
REQ-014 SHALL have port write_data_b  input  DATA_W  port B write data.
REQ-015 SHALL have port data_out_b  output  DATA_W  port B registered read data.
REQ-016 SHALL have port valid_b  output  1  data_out_b updated this cycle.
REQ-017 SHALL have port busy  output  1  clear sequence in progress; port requests ignored.

Function
REQ-018 SHALL implement states CLEAR and READY in a registered state machine.
REQ-019 SHALL, in CLEAR, write zero to word clr_cnt each cycle, clr_cnt counting 0..DEPTH-1, then enter READY on the cycle after writing DEPTH-1 (busy high for exactly DEPTH cycles).
REQ-020 SHALL, in CLEAR, ignore re_a, re_b, we_b; instr_out, data_out_b hold 0; valid_a, valid_b low.
REQ-021 SHALL, in READY, on edge with re_a=1, load instr_out <= mem[addr_a] and drive valid_a=1 the following cycle (1-cycle latency).
REQ-022 SHALL, in READY, with we_b=1, write mem[addr_b] <= write_data_b on that edge, load data_out_b per RDW_MODE (new data if 0, prior content if 1), and drive valid_b=1; re_b is don't-care when we_b=1.
REQ-023 SHALL, in READY, with re_b=1 and we_b=0, load data_out_b <= mem[addr_b], valid_b=1 next cycle.
REQ-024 SHALL hold instr_out/data_out_b and drive valid_a/valid_b low in any cycle following an edge with no request on that port.
REQ-025 SHALL, when re_a=1, we_b=1 and addr_a==addr_b on one edge, return write_data_b on instr_out if RDW_MODE=0, prior content if RDW_MODE=1.
REQ-026 SHALL allow both ports active every cycle with no stall; different addresses are independent.
REQ-027 SHALL wrap addresses naturally (no out-of-range condition; addr width equals DEPTH exactly).

Reset
REQ-028 SHALL, on edge with rst=1, set instr_out=0, data_out_b=0, valid_a=0, valid_b=0, clr_cnt=0, and perform no memory write from ports.
REQ-029 SHALL leave reset in CLEAR (busy=1) if CLEAR_ON_RST=1, else in READY (busy=0) with contents preserved.
REQ-030 SHALL restart the clear from address 0 if rst is asserted mid-CLEAR; rst has priority over all other inputs.

Verification
REQ-031 SHALL verify clear: ADDR_W=4, CLEAR_ON_RST=1, rst high 2 cycles then low -> busy high exactly 16 cycles; then reads of addr 0..15 return 0x00, valid 1 cycle after request.
REQ-032 SHALL verify write/read: we_b=1 addr_b=5 data 0xAA, next cycle re_b=1 addr_b=5 -> data_out_b=0xAA, valid_b=1; idle cycle -> valid_b=0, data_out_b holds 0xAA.
REQ-033 SHALL verify cross-port collision: mem[20]=0x11, then same edge we_b=1 addr_b=20 data 0xF0 and re_a=1 addr_a=20 -> instr_out=0xF0 and data_out_b=0xF0 (RDW_MODE=0); instr_out=0x11 and data_out_b=0x11 (RDW_MODE=1).
REQ-034 SHALL verify concurrent independence: mem[10]=0x33, same edge we_b=1 addr_b=5 data 0x55 and re_a=1 addr_a=10 -> instr_out=0x33, data_out_b=0x55.
REQ-035 SHALL verify mid-clear reset and request blocking: ADDR_W=4, rst at clear cycle 7 -> busy stays high 16 further cycles; we_b=1 addr_b=3 data 0x77 during busy -> addr 3 reads 0x00 afterwards.
REQ-036 SHALL verify DATA_W=16, CLEAR_ON_RST=0: write 0xBEEF at addr 0xFF, assert rst 1 cycle, read addr 0xFF -> 0xBEEF, busy never high.
